// File: rtl/crack_ctrl.sv
// crack_ctrl: walks a key range through the arc4 core and reports the first
// key whose plaintext is entirely printable. Owns the pt_mem port mux.
module crack_ctrl #(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter int               KEY_STEP  = 1,
  parameter logic [KEY_W-1:0] KEY_LAST  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic [KEY_W-1:0] keys_tried,
  output logic             arc_en,
  input  logic             arc_rdy,
  output logic [KEY_W-1:0] arc_key,
  input  logic [7:0]       arc_pt_addr,
  input  logic [7:0]       arc_pt_wrdata,
  input  logic             arc_pt_wren,
  output logic [7:0]       pt_addr,
  output logic [7:0]       pt_wrdata,
  output logic             pt_wren,
  input  logic [7:0]       pt_rddata
);

  typedef enum logic [3:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RD_LEN, GET_LEN, CHECK, NEXT_KEY, DONE
  } state_t;

  state_t           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic [KEY_W-1:0] keys_tried_q, keys_tried_d;
  logic             arc_en_q, arc_en_d;
  logic [KEY_W-1:0] arc_key_q, arc_key_d;
  logic [7:0]       ctl_addr_q, ctl_addr_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;

  logic             found;
  logic             byte_ok;
  logic             arc_owns_pt;
  // One extra bit so the range check cannot wrap past KEY_LAST.
  logic [KEY_W:0]   next_key_w;

  assign next_key_w = {1'b0, arc_key_q} + (KEY_W+1)'(KEY_STEP);
  assign byte_ok    = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

  // Next-state and next-output logic for the search FSM.
  always_comb begin
    state_d      = state_q;
    rdy_d        = rdy_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    keys_tried_d = keys_tried_q;
    arc_en_d     = 1'b0;
    arc_key_d    = arc_key_q;
    ctl_addr_d   = ctl_addr_q;
    len_d        = len_q;
    idx_d        = idx_q;
    found        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          key_valid_d  = 1'b0;
          keys_tried_d = '0;
          arc_key_d    = KEY_START;
          ctl_addr_d   = 8'd0;
          rdy_d        = 1'b0;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        if (arc_rdy) begin
          arc_en_d = 1'b1;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (!arc_rdy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (arc_rdy) begin
          ctl_addr_d = 8'd0;
          state_d    = RD_LEN;
        end
      end
      RD_LEN: state_d = GET_LEN;
      GET_LEN: begin
        len_d = pt_rddata;
        if (pt_rddata == 8'd0) begin
          found = 1'b1;
        end else begin
          ctl_addr_d = 8'd1;
          idx_d      = 8'd0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        // idx_q is the byte on pt_rddata; idx 0 is the pipeline fill (length byte).
        ctl_addr_d = ctl_addr_q + 8'd1;
        idx_d      = idx_q + 8'd1;
        if (idx_q != 8'd0) begin
          if (!byte_ok)            state_d = NEXT_KEY;
          else if (idx_q == len_q) found   = 1'b1;
        end
      end
      NEXT_KEY: begin
        keys_tried_d = keys_tried_q + KEY_W'(1);
        if (next_key_w > {1'b0, KEY_LAST}) begin
          rdy_d   = 1'b1;
          state_d = DONE;
        end else begin
          arc_key_d = next_key_w[KEY_W-1:0];
          state_d   = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (found) begin
      key_d        = arc_key_q;
      key_valid_d  = 1'b1;
      keys_tried_d = keys_tried_q + KEY_W'(1);
      rdy_d        = 1'b1;
      state_d      = DONE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rdy_q        <= 1'b1;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      keys_tried_q <= '0;
      arc_en_q     <= 1'b0;
      arc_key_q    <= KEY_START;
      ctl_addr_q   <= 8'd0;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      keys_tried_q <= keys_tried_d;
      arc_en_q     <= arc_en_d;
      arc_key_q    <= arc_key_d;
      ctl_addr_q   <= ctl_addr_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
    end
  end

  // pt_mem port: arc4 owns it while a key is being decrypted, else read-only checker.
  always_comb begin
    arc_owns_pt = (state_q == LAUNCH) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    pt_addr     = arc_owns_pt ? arc_pt_addr   : ctl_addr_q;
    pt_wrdata   = arc_owns_pt ? arc_pt_wrdata : 8'd0;
    pt_wren     = arc_owns_pt & arc_pt_wren;
  end

  assign rdy        = rdy_q;
  assign key        = key_q;
  assign key_valid  = key_valid_q;
  assign keys_tried = keys_tried_q;
  assign arc_en     = arc_en_q;
  assign arc_key    = arc_key_q;

endmodule

// File: tb/tb_crack_ctrl.sv
// Bench for crack_ctrl: three instances (normal, exhaustion, stepped) each with
// a behavioural arc4 stand-in and pt_mem. The arc4 stand-in emits a printable
// message only for its configured good key; other keys get one bad byte.
module tb_crack_ctrl;
  localparam int N = 3;
  localparam logic [23:0] KS    [N] = '{24'h1E45FE, 24'h000000, 24'h000001};
  localparam logic [23:0] KL    [N] = '{24'hFFFFFF, 24'h000002, 24'h000004};
  localparam int          KSTEP [N] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]       en, rdy, key_valid, arc_en, arc_rdy, arc_pt_wren, pt_wren;
  logic [N-1:0][23:0] key, keys_tried, arc_key;
  logic [N-1:0][7:0]  arc_pt_addr, arc_pt_wrdata, pt_addr, pt_wrdata, pt_rddata;
  logic [23:0]        good_key [N];
  int                 mlen [N];
  int                 n_tests = 0;
  int                 n_fail  = 0;

  // Plaintext byte i for key k: length at 0, boundary printables at 1 and len.
  function automatic logic [7:0] pbyte(input logic [23:0] k, input logic [23:0] gk,
                                       input int len, input int i);
    if (i == 0) return 8'(len);
    if (k != gk && i == (int'(k) % len) + 1) return k[0] ? 8'h7F : 8'h1F;
    if (i == 1) return 8'h20;
    if (i == len) return 8'h7E;
    return 8'h40 + 8'(i);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_inst
    logic        ar_q, we_q;
    logic [7:0]  wa_q, wd_q, rd_q;
    logic [23:0] kl_q;
    int          ph;
    logic [7:0]  mem [256];
    int          pulses = 0;
    int          viol   = 0;
    int          nseen  = 0;
    logic [23:0] seen [4];
    logic [23:0] maxkey = '0;
    logic        en_prev = 1'b0;

    assign arc_rdy[g]       = ar_q;
    assign arc_pt_wren[g]   = we_q;
    assign arc_pt_addr[g]   = wa_q;
    assign arc_pt_wrdata[g] = wd_q;
    assign pt_rddata[g]     = rd_q;

    crack_ctrl #(.KEY_W(24), .KEY_START(KS[g]), .KEY_STEP(KSTEP[g]), .KEY_LAST(KL[g])) dut (
      .clk(clk), .rst(rst), .en(en[g]), .rdy(rdy[g]), .key(key[g]),
      .key_valid(key_valid[g]), .keys_tried(keys_tried[g]), .arc_en(arc_en[g]),
      .arc_rdy(arc_rdy[g]), .arc_key(arc_key[g]), .arc_pt_addr(arc_pt_addr[g]),
      .arc_pt_wrdata(arc_pt_wrdata[g]), .arc_pt_wren(arc_pt_wren[g]),
      .pt_addr(pt_addr[g]), .pt_wrdata(pt_wrdata[g]), .pt_wren(pt_wren[g]),
      .pt_rddata(pt_rddata[g]));

    // pt_mem: registered read, data valid the cycle after the address.
    always @(posedge clk) begin
      if (pt_wren[g]) mem[pt_addr[g]] <= pt_wrdata[g];
      rd_q <= mem[pt_addr[g]];
    end

    // arc4 stand-in; while idle it drives a stray write of 0x07 to byte 1,
    // which corrupts the good message if the mux ever lets it through.
    always @(posedge clk) begin
      if (rst) begin
        ar_q <= 1'b1; we_q <= 1'b0; wa_q <= 8'd0; wd_q <= 8'd0; ph <= 0; kl_q <= '0;
      end else if (ar_q) begin
        if (arc_en[g]) begin
          ar_q <= 1'b0; we_q <= 1'b0; ph <= 0; kl_q <= arc_key[g];
        end else begin
          wa_q <= 8'd1; wd_q <= 8'h07; we_q <= 1'b1;
        end
      end else if (ph <= mlen[g]) begin
        wa_q <= 8'(ph); wd_q <= pbyte(kl_q, good_key[g], mlen[g], ph); we_q <= 1'b1;
        ph <= ph + 1;
      end else if (ph == mlen[g] + 1) begin
        we_q <= 1'b0; ph <= ph + 1;
      end else begin
        ar_q <= 1'b1; ph <= 0;
      end
    end

    // Continuous protocol and mux monitors.
    always @(negedge clk) begin
      if (!rst) begin
        if (arc_en[g]) begin
          pulses++;
          if (nseen < 4) seen[nseen] = arc_key[g];
          nseen++;
          if (en_prev || !arc_rdy[g]) viol++;
        end
        if (pt_wren[g] && (!arc_pt_wren[g] || pt_addr[g] != arc_pt_addr[g] ||
                           pt_wrdata[g] != arc_pt_wrdata[g])) viol++;
        if (rdy[g] && pt_wren[g]) viol++;
        if (arc_key[g] > maxkey) maxkey = arc_key[g];
      end
      en_prev = arc_en[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse (or hold) en on the masked instances and wait for them all to finish.
  task automatic run(input logic [N-1:0] m, input bit hold, output int cyc);
    en = m;
    @(negedge clk);
    chk("rdy_drop", 32'(rdy & m), 32'd0);
    if (!hold) en = '0;
    cyc = 0;
    while ((rdy & m) != m && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk("done_in_time", 32'(cyc < 3000), 32'd1);
    en = '0;
  endtask

  initial begin
    int cyc, p0, p1, p2;
    en       = '0;
    good_key = '{24'h1E4600, 24'hFFFFFF, 24'hFFFFFF};
    mlen     = '{5, 4, 3};
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rdy",       32'(rdy), 32'h7);
    chk("rst_key",       32'(key[0]), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_tried",     32'(keys_tried[0]), 32'h0);
    chk("rst_arc_en",    32'(arc_en), 32'h0);
    chk("rst_arc_key0",  32'(arc_key[0]), 32'h1E45FE);
    chk("rst_arc_key2",  32'(arc_key[2]), 32'h000001);
    chk("rst_pt_wren",   32'(pt_wren), 32'h0);
    chk("rst_pt_addr",   32'(pt_addr[0]), 32'h0);
    chk("rst_pt_wrdata", 32'(pt_wrdata[0]), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Target key, exhaustion and stepped search all at once
    p0 = g_inst[0].pulses; p1 = g_inst[1].pulses; p2 = g_inst[2].pulses;
    run(3'b111, 1'b0, cyc);
    chk("find_key",      32'(key[0]), 32'h1E4600);
    chk("find_valid",    32'(key_valid[0]), 32'h1);
    chk("find_tried",    32'(keys_tried[0]), 32'h3);
    chk("find_pulses",   32'(g_inst[0].pulses - p0), 32'd3);
    chk("exh_valid",     32'(key_valid[1]), 32'h0);
    chk("exh_tried",     32'(keys_tried[1]), 32'h3);
    chk("exh_maxkey",    32'(g_inst[1].maxkey), 32'h2);
    chk("exh_pulses",    32'(g_inst[1].pulses - p1), 32'd3);
    chk("step_valid",    32'(key_valid[2]), 32'h0);
    chk("step_tried",    32'(keys_tried[2]), 32'h2);
    chk("step_pulses",   32'(g_inst[2].pulses - p2), 32'd2);
    chk("step_key_a",    32'(g_inst[2].seen[0]), 32'h1);
    chk("step_key_b",    32'(g_inst[2].seen[1]), 32'h3);
    chk("step_arc_key",  32'(arc_key[2]), 32'h3);
    repeat (5) @(negedge clk);
    chk("done_hold_key", 32'(key[0]), 32'h1E4600);
    chk("done_hold_rdy", 32'(rdy), 32'h7);

    // Zero-length message: found on first key, no CHECK cycles
    mlen[0] = 0;
    p0 = g_inst[0].pulses;
    run(3'b001, 1'b0, cyc);
    chk("zlen_cycles",   32'(cyc), 32'd8);
    chk("zlen_key",      32'(key[0]), 32'h1E45FE);
    chk("zlen_valid",    32'(key_valid[0]), 32'h1);
    chk("zlen_tried",    32'(keys_tried[0]), 32'h1);
    chk("zlen_pulses",   32'(g_inst[0].pulses - p0), 32'd1);

    // en held high for the whole search: no restart before DONE
    mlen[0] = 5;
    p0 = g_inst[0].pulses;
    run(3'b001, 1'b1, cyc);
    chk("hold_tried",    32'(keys_tried[0]), 32'h3);
    chk("hold_key",      32'(key[0]), 32'h1E4600);
    chk("hold_pulses",   32'(g_inst[0].pulses - p0), 32'd3);
    @(negedge clk);
    chk("hold_stay_rdy", 32'(rdy[0]), 32'h1);

    // Reset while in WAIT_DONE with arc4 mid-write
    en = 3'b001;
    @(negedge clk);
    en = '0;
    cyc = 0;
    while (arc_rdy[0] && cyc < 100) begin cyc++; @(negedge clk); end
    chk("arc_busy_seen", 32'(arc_rdy[0]), 32'h0);
    repeat (2) @(negedge clk);
    chk("pass_wren",     32'(pt_wren[0]), 32'h1);
    chk("pass_addr",     32'(pt_addr[0]), 32'h1);
    chk("pass_data",     32'(pt_wrdata[0]), 32'h20);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy",   32'(rdy[0]), 32'h1);
    chk("mid_rst_key",   32'(key[0]), 32'h0);
    chk("mid_rst_valid", 32'(key_valid[0]), 32'h0);
    chk("mid_rst_tried", 32'(keys_tried[0]), 32'h0);
    chk("mid_rst_akey",  32'(arc_key[0]), 32'h1E45FE);
    chk("mid_rst_aen",   32'(arc_en[0]), 32'h0);
    chk("mid_rst_wren",  32'(pt_wren[0]), 32'h0);
    chk("mid_rst_addr",  32'(pt_addr[0]), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("protocol_viol0", 32'(g_inst[0].viol), 32'd0);
    chk("protocol_viol1", 32'(g_inst[1].viol), 32'd0);
    chk("protocol_viol2", 32'(g_inst[2].viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
